// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared state, instruction-class and MIPS field encodings
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    MULDIV = 3'd4,
    HALTED = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOWR   = 3'd0,
    CLS_ALUWR  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_MULDIV = 3'd4
  } instr_class_e;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'd0,  OP_REGIMM = 6'd1,  OP_J     = 6'd2,  OP_JAL   = 6'd3,
    OP_BEQ     = 6'd4,  OP_BNE    = 6'd5,  OP_BLEZ  = 6'd6,  OP_BGTZ  = 6'd7,
    OP_ADDI    = 6'd8,  OP_ADDIU  = 6'd9,  OP_SLTI  = 6'd10, OP_SLTIU = 6'd11,
    OP_ANDI    = 6'd12, OP_ORI    = 6'd13, OP_XORI  = 6'd14, OP_LUI   = 6'd15,
    OP_LB      = 6'd32, OP_LH     = 6'd33, OP_LWL   = 6'd34, OP_LW    = 6'd35,
    OP_LBU     = 6'd36, OP_LHU    = 6'd37, OP_LWR   = 6'd38,
    OP_SB      = 6'd40, OP_SH     = 6'd41, OP_SW    = 6'd43
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'd0,  FN_SRL   = 6'd2,  FN_SRA  = 6'd3,  FN_SLLV  = 6'd4,
    FN_SRLV = 6'd6,  FN_SRAV  = 6'd7,  FN_JR   = 6'd8,  FN_JALR  = 6'd9,
    FN_MFHI = 6'd16, FN_MTHI  = 6'd17, FN_MFLO = 6'd18, FN_MTLO  = 6'd19,
    FN_MULT = 6'd24, FN_MULTU = 6'd25, FN_DIV  = 6'd26, FN_DIVU  = 6'd27,
    FN_ADD  = 6'd32, FN_ADDU  = 6'd33, FN_SUB  = 6'd34, FN_SUBU  = 6'd35,
    FN_AND  = 6'd36, FN_OR    = 6'd37, FN_XOR  = 6'd38, FN_NOR   = 6'd39,
    FN_SLT  = 6'd42, FN_SLTU  = 6'd43
  } funct_e;

  typedef enum logic [4:0] {
    RT_BLTZ   = 5'd0,
    RT_BGEZ   = 5'd1,
    RT_BLTZAL = 5'd16,
    RT_BGEZAL = 5'd17
  } rt_e;

endpackage

// File: rtl/mips_cpu_control_fsm_if.sv
// rtl/mips_cpu_control_fsm_if.sv - instruction/data memory handshake between controller and memory
interface mips_cpu_control_fsm_if;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        mem_read;
  logic        mem_write;

  modport master (
    input  mem_readdata,
    input  mem_waitrequest,
    output mem_read,
    output mem_write
  );

  modport slave (
    output mem_readdata,
    output mem_waitrequest,
    input  mem_read,
    input  mem_write
  );
endinterface

// File: rtl/mips_cpu_instr_class.sv
// rtl/mips_cpu_instr_class.sv - combinational decode of the IR into a sequencing class
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e cls
);
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    cls = CLS_NOWR;
    case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MULDIV;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JALR,
          FN_MFHI, FN_MFLO, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:  cls = CLS_ALUWR;
          default:                                         cls = CLS_NOWR;
        endcase
      end
      // Only the linking REGIMM branches write a register ($31).
      OP_REGIMM: begin
        if (instr[20:16] == RT_BLTZAL || instr[20:16] == RT_BGEZAL) cls = CLS_ALUWR;
      end
      OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                    cls = CLS_ALUWR;
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR:  cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SW:                                 cls = CLS_STORE;
      default:                                             cls = CLS_NOWR;
    endcase
  end
endmodule

// File: rtl/mips_cpu_control_fsm.sv
// rtl/mips_cpu_control_fsm.sv - multicycle MIPS control sequencer with IR, mul/div busy counter and halt
module mips_cpu_control_fsm
  import mips_cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_cpu_control_fsm_if.master bus,
  input  logic                   pc_next_zero,
  output logic [31:0]            Instr,
  output logic                   pc_write,
  output logic                   reg_write,
  output logic                   spc_reg_write,
  output logic                   active,
  output logic [2:0]             state
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  instr_class_e     instr_cls;
  logic             is_div, is_mthilo, end_instr;
  logic             mem_read_s, mem_write_s;

  mips_cpu_instr_class u_instr_class (
    .instr (ir_q),
    .cls   (instr_cls)
  );

  assign is_div    = (ir_q[5:0] == FN_DIV) || (ir_q[5:0] == FN_DIVU);
  assign is_mthilo = (ir_q[31:26] == OP_SPECIAL) &&
                     ((ir_q[5:0] == FN_MTHI) || (ir_q[5:0] == FN_MTLO));

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    end_instr = 1'b0;
    case (state_q)
      FETCH: begin
        if (!bus.mem_waitrequest) begin
          ir_d    = bus.mem_readdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (instr_cls)
          CLS_LOAD, CLS_STORE: state_d = MEM;
          CLS_MULDIV: begin
            cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
            state_d = MULDIV;
          end
          default: end_instr = 1'b1;
        endcase
      end
      MEM: begin
        if (!bus.mem_waitrequest) begin
          if (instr_cls == CLS_LOAD) state_d = WB;
          else                       end_instr = 1'b1;
        end
      end
      WB: end_instr = 1'b1;
      // The counter holds at zero; the zero cycle is the final busy cycle.
      MULDIV: begin
        if (cnt_q == '0) end_instr = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
    if (end_instr) state_d = pc_next_zero ? HALTED : FETCH;
    active_d = (state_d != HALTED);
  end

  always_comb begin
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    spc_reg_write = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: mem_read_s = 1'b1;
        EXEC: begin
          reg_write     = (instr_cls == CLS_ALUWR);
          pc_write      = (instr_cls == CLS_ALUWR) || (instr_cls == CLS_NOWR);
          spc_reg_write = is_mthilo;
        end
        MEM: begin
          mem_read_s  = (instr_cls == CLS_LOAD);
          mem_write_s = (instr_cls == CLS_STORE);
          pc_write    = (instr_cls == CLS_STORE) && !bus.mem_waitrequest;
        end
        WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        MULDIV: begin
          spc_reg_write = (cnt_q == '0);
          pc_write      = (cnt_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bus.mem_read  = mem_read_s;
  assign bus.mem_write = mem_write_s;
  assign Instr         = ir_q;
  assign active        = active_q;
  assign state         = state_q;
endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// tb/tb_mips_cpu_control_fsm.sv - randomized and directed bench against an instruction-timeline model
module tb_mips_cpu_control_fsm;
  import mips_cpu_pkg::*;

  localparam int MULC = 4;
  localparam int DIVC = 32;
  localparam int K_NOWR = 0, K_ALUWR = 1, K_LOAD = 2, K_STORE = 3, K_MULDIV = 4;

  typedef struct {
    state_e st;
    bit rd; bit wr; bit pcw; bit rw; bit spc; bit wt;
  } cyc_t;

  logic        clk, reset, pc_next_zero;
  logic [31:0] Instr;
  logic        pc_write, reg_write, spc_reg_write, active;
  logic [2:0]  state;
  logic [31:0] model_ir;
  int          checks = 0;
  int          errors = 0;

  mips_cpu_control_fsm_if mem_bus();

  mips_cpu_control_fsm #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (mem_bus),
    .pc_next_zero  (pc_next_zero),
    .Instr         (Instr),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .spc_reg_write (spc_reg_write),
    .active        (active),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input logic [31:0] w);
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    int rt = int'(w[20:16]);
    if (op >= 32 && op <= 38) return K_LOAD;
    if (op == 40 || op == 41 || op == 43) return K_STORE;
    if (op == 0) begin
      if (fn >= 24 && fn <= 27) return K_MULDIV;
      if (fn inside {0, 2, 3, 4, 6, 7, 9, 16, 18, 42, 43} || (fn >= 32 && fn <= 39)) return K_ALUWR;
      return K_NOWR;
    end
    if (op == 1) return (rt == 16 || rt == 17) ? K_ALUWR : K_NOWR;
    if (op == 3 || (op >= 8 && op <= 15)) return K_ALUWR;
    return K_NOWR;
  endfunction

  function automatic cyc_t mk(state_e st, bit rd, bit wr, bit pcw, bit rw, bit spc, bit wt);
    cyc_t c;
    c.st = st; c.rd = rd; c.wr = wr; c.pcw = pcw; c.rw = rw; c.spc = spc; c.wt = wt;
    return c;
  endfunction

  task automatic drive(input bit rst, input bit wt, input logic [31:0] rdata, input bit pnz);
    @(negedge clk);
    reset = rst;
    mem_bus.mem_waitrequest = wt;
    mem_bus.mem_readdata = rdata;
    pc_next_zero = pnz;
    #1;
  endtask

  // Expands one instruction into its expected cycle-by-cycle timeline, then drives and compares.
  task automatic run_instr(input string name, input logic [31:0] w, input int fw, input int mw, input bit halt);
    cyc_t q[$];
    int cls, n;
    bit mthilo;
    logic [8:0] got, exp;
    logic [31:0] exp_ir;
    cls = classify(w);
    mthilo = (w[31:26] == 6'd0) && (w[5:0] == 6'd17 || w[5:0] == 6'd19);
    for (int i = 0; i <= fw; i++) q.push_back(mk(FETCH, 1, 0, 0, 0, 0, i < fw));
    q.push_back(mk(EXEC, 0, 0, cls == K_ALUWR || cls == K_NOWR, cls == K_ALUWR, mthilo, 0));
    if (cls == K_LOAD || cls == K_STORE) begin
      for (int i = 0; i <= mw; i++)
        q.push_back(mk(MEM, cls == K_LOAD, cls == K_STORE, cls == K_STORE && i == mw, 0, 0, i < mw));
      if (cls == K_LOAD) q.push_back(mk(WB, 0, 0, 1, 1, 0, 0));
    end
    if (cls == K_MULDIV) begin
      n = (int'(w[5:0]) >= 26) ? DIVC : MULC;
      for (int i = 0; i < n; i++) q.push_back(mk(MULDIV, 0, 0, i == n - 1, 0, i == n - 1, 0));
    end
    for (int k = 0; k < q.size(); k++) begin
      drive(0, q[k].wt, (q[k].st == FETCH && !q[k].wt) ? w : $urandom,
            (k == q.size() - 1) ? halt : 1'($urandom));
      got = {state, mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write, active};
      exp = {q[k].st, q[k].rd, q[k].wr, q[k].pcw, q[k].rw, q[k].spc, 1'b1};
      exp_ir = (q[k].st == FETCH) ? model_ir : w;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s %h cyc%0d state/rd/wr/pcw/rw/spc/active: got %b exp %b", name, w, k, got, exp);
      end
      checks++;
      if (Instr !== exp_ir) begin
        errors++;
        $display("FAIL %s cyc%0d Instr: got %h exp %h", name, k, Instr, exp_ir);
      end
      checks++;
      if (mem_bus.mem_read === 1'b1 && mem_bus.mem_write === 1'b1) begin
        errors++;
        $display("FAIL %s cyc%0d rd_wr_exclusive: got rd=1 wr=1 exp not both", name, k);
      end
    end
    model_ir = w;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'($urandom), $urandom, 1'($urandom));
      checks++;
      if ({mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write} !== 5'b0) begin
        errors++;
        $display("FAIL reset_strobes: got %b exp 00000",
                 {mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write});
      end
    end
    drive(0, 1, $urandom, 0);
    checks++;
    if ({state, Instr, active, mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write}
        !== {FETCH, 32'h0, 1'b1, 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d ir=%h act=%b rd=%b exp st=0 ir=0 act=1 rd=1",
               state, Instr, active, mem_bus.mem_read);
    end
    model_ir = 32'h0;
  endtask

  task automatic test_alu;
    run_instr("addiu", 32'h24420005, 0, 0, 0);
    run_instr("mthi", 32'h00400011, 1, 0, 0);
    run_instr("jal", 32'h0C000010, 0, 0, 0);
  endtask

  task automatic test_load_store;
    run_instr("lw_wait2", 32'h8C430004, 0, 2, 0);
    run_instr("sw", 32'hAC430000, 2, 0, 0);
  endtask

  task automatic test_muldiv;
    run_instr("mult", 32'h00430018, 0, 0, 0);
    run_instr("divu", 32'h0043001B, 0, 0, 0);
  endtask

  task automatic test_random;
    int op_tab [12] = '{0, 0, 0, 1, 2, 4, 9, 15, 35, 38, 40, 43};
    int fn_tab [10] = '{8, 9, 16, 17, 19, 24, 25, 26, 33, 42};
    logic [31:0] w;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 5) != 0) begin
        w[31:26] = 6'(op_tab[$urandom_range(0, 11)]);
        if ($urandom_range(0, 1) == 1) w[5:0] = 6'(fn_tab[$urandom_range(0, 9)]);
        if (w[31:26] == 6'd1 && $urandom_range(0, 1) == 1) w[20:16] = 5'(16 + $urandom_range(0, 1));
      end
      run_instr("random", w, $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_reset_mid_store;
    drive(0, 0, 32'hAC430000, 0);
    drive(0, 0, $urandom, 0);
    drive(0, 1, $urandom, 0);
    checks++;
    if (mem_bus.mem_write !== 1'b1 || state !== MEM) begin
      errors++;
      $display("FAIL sw_mem_wait1: got wr=%b st=%0d exp wr=1 st=%0d", mem_bus.mem_write, state, MEM);
    end
    drive(1, 1, $urandom, 1);
    checks++;
    if ({mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write} !== 5'b0) begin
      errors++;
      $display("FAIL sw_reset_strobes: got wr=%b pcw=%b exp 0", mem_bus.mem_write, pc_write);
    end
    drive(0, 1, $urandom, 0);
    checks++;
    if ({state, Instr, mem_bus.mem_write, active} !== {FETCH, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sw_after_reset: got st=%0d ir=%h wr=%b act=%b exp st=0 ir=0 wr=0 act=1",
               state, Instr, mem_bus.mem_write, active);
    end
    model_ir = 32'h0;
  endtask

  task automatic test_reset_mid_muldiv;
    drive(0, 0, 32'h0043001A, 0);
    drive(0, 0, $urandom, 0);
    for (int i = 0; i < 5; i++) drive(0, 1'($urandom), $urandom, 1'($urandom));
    checks++;
    if (state !== MULDIV || spc_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL div_midcount: got st=%0d spc=%b exp st=%0d spc=0", state, spc_reg_write, MULDIV);
    end
    drive(1, 0, $urandom, 1);
    checks++;
    if ({pc_write, spc_reg_write, reg_write} !== 3'b0) begin
      errors++;
      $display("FAIL div_reset_strobes: got %b exp 000", {pc_write, spc_reg_write, reg_write});
    end
    drive(0, 1, $urandom, 0);
    checks++;
    if ({state, Instr, active} !== {FETCH, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL div_after_reset: got st=%0d ir=%h act=%b exp st=0 ir=0 act=1", state, Instr, active);
    end
    model_ir = 32'h0;
    run_instr("mult_after_reset", 32'h00430019, 0, 0, 0);
  endtask

  task automatic test_halt;
    run_instr("jr_halt", 32'h03E00008, 0, 0, 1);
    for (int i = 0; i < 21; i++) begin
      drive(0, 1'($urandom), $urandom, 1'($urandom));
      checks++;
      if ({state, mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write, active}
          !== {HALTED, 6'b0}) begin
        errors++;
        $display("FAIL halted_cyc%0d: got st=%0d strobes=%b act=%b exp st=%0d strobes=00000 act=0", i, state,
                 {mem_bus.mem_read, mem_bus.mem_write, pc_write, reg_write, spc_reg_write}, active, HALTED);
      end
    end
    drive(1, 0, $urandom, 1);
    drive(0, 1, $urandom, 0);
    checks++;
    if ({state, Instr, active} !== {FETCH, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL halt_reset: got st=%0d ir=%h act=%b exp st=0 ir=0 act=1", state, Instr, active);
    end
    model_ir = 32'h0;
    run_instr("addiu_after_halt", 32'h24420005, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    pc_next_zero = 1'b0;
    mem_bus.mem_waitrequest = 1'b1;
    mem_bus.mem_readdata = 32'h0;
    model_ir = 32'h0;
    test_reset();
    test_alu();
    test_load_store();
    test_muldiv();
    test_random();
    test_reset_mid_store();
    test_reset_mid_muldiv();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish by 400000 exp finish");
    $fatal(1);
  end
endmodule

// File: doc/mips_cpu_control_fsm.md
MIPS_CPU_CONTROL_FSM -- requirements
Module: mips_cpu_control_fsm

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4: the multiply busy period in cycles (1..64).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 32: the divide busy period in cycles (1..64).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port mem_readdata, input, 32 bits: the instruction word from memory during FETCH.
REQ-006 The block SHALL have port mem_waitrequest, input, 1 bit: high means the memory has not completed the current access.
REQ-007 The block SHALL have port pc_next_zero, input, 1 bit: high means the datapath's next-PC value equals 0x00000000.
REQ-008 The block SHALL have port Instr, output, 32 bits: the registered instruction (IR).
REQ-009 The block SHALL have port mem_read, output, 1 bit: memory read strobe.
REQ-010 The block SHALL have port mem_write, output, 1 bit: memory write strobe.
REQ-011 The block SHALL have port pc_write, output, 1 bit: PC update pulse.
REQ-012 The block SHALL have port reg_write, output, 1 bit: register-file write-enable pulse.
REQ-013 The block SHALL have port spc_reg_write, output, 1 bit: HI/LO write-enable pulse.
REQ-014 The block SHALL have port active, output, 1 bit: high until the CPU halts.
REQ-015 The block SHALL have port state, output, 3 bits: the current FSM state encoding.

Function
REQ-016 States SHALL be FETCH, EXEC, MEM, WB, MULDIV, HALTED.
REQ-017 IR opcode SHALL decode to these classes: LOAD (opcodes 32-38), STORE (40, 41, 43), MULDIV (SPECIAL with funct 24-27), ALUWR (ALU and link instructions that write rd/rt), NOWR (branches, J, JR, MTHI, MTLO, unknown).
REQ-018 FETCH SHALL assert mem_read; while mem_waitrequest=1 it SHALL hold state and IR; when mem_waitrequest=0 it SHALL load IR from mem_readdata and go to EXEC.
REQ-019 In EXEC, a LOAD or STORE instruction SHALL go to MEM.
REQ-020 In EXEC, a MULDIV instruction SHALL load the counter with MUL_CYCLES-1 (funct 24/25) or DIV_CYCLES-1 (funct 26/27) and go to MULDIV; MTHI/MTLO SHALL pulse spc_reg_write in EXEC.
REQ-021 In EXEC, an ALUWR instruction SHALL pulse reg_write; ALUWR and NOWR instructions SHALL pulse pc_write and end the instruction.
REQ-022 MEM SHALL assert mem_read (LOAD) or mem_write (STORE), held while mem_waitrequest=1; on release, LOAD SHALL go to WB, while STORE SHALL pulse pc_write and end the instruction.
REQ-023 WB SHALL pulse reg_write and pc_write and end the instruction.
REQ-024 MULDIV SHALL decrement the counter each cycle; when the counter is 0 it SHALL pulse spc_reg_write and pc_write and end the instruction.
REQ-025 Ending an instruction SHALL go to FETCH, or to HALTED if pc_next_zero=1 in the same cycle.
REQ-026 HALTED SHALL drive active=0 and all strobes 0, and remain until reset.
REQ-027 Latency SHALL be 2 cycles for ALU/branch, 3 for store, 4 for load, and 2+MUL_CYCLES / 2+DIV_CYCLES for MULDIV, each plus memory wait cycles.
REQ-028 Strobes SHALL be combinational from state, IR and mem_waitrequest, and each pulse SHALL last exactly one cycle.
REQ-029 mem_read and mem_write SHALL never both be 1.
REQ-030 The counter width SHALL be $clog2 of the larger parameter, and the counter SHALL not wrap below 0.

Reset
REQ-031 reset=1 SHALL, at the next edge and from any state (including MEM mid-wait or MULDIV mid-count), set state=FETCH, IR=0, counter=0 and active=1.
REQ-032 While reset=1, all strobes SHALL be 0.
REQ-033 reset SHALL take priority over every other event in the same cycle.

Structure
REQ-034 Opcode/funct/rt enums and the state enum SHALL live in the shared package mips_cpu_pkg.
REQ-035 Instruction classification SHALL be a sub-module mips_cpu_instr_class (combinational, IR in, class out).

Verification
REQ-036 Test: ADDIU 0x24420005, waitrequest=0 -> state FETCH,EXEC,FETCH; reg_write and pc_write high in cycle 2 only.
REQ-037 Test: LW 0x8C430004 with waitrequest high for 2 MEM cycles -> mem_read high for 3 MEM cycles, then WB with reg_write=1; total 6 cycles.
REQ-038 Test: MULT 0x00430018 with MUL_CYCLES=4 -> 4 MULDIV cycles; spc_reg_write pulses once, on the last; reg_write never asserted.
REQ-039 Test: JR 0x03E00008 with pc_next_zero=1 in EXEC -> HALTED next cycle, active=0, strobes 0 for 20 further cycles.
REQ-040 Test: reset asserted during the second MEM wait cycle of SW 0xAC430000 -> next cycle state=FETCH, mem_write=0, IR=0.
